// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller and its
// decoder-based full-adder cell.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit i set means minterm i of {a,b,c} belongs to the function.
    localparam logic [7:0] SUM_MINTERMS   = 8'b1001_0110; // 1,2,4,7
    localparam logic [7:0] CARRY_MINTERMS = 8'b1110_1000; // 3,5,6,7

endpackage

// File: rtl/serial_add_ctrl_fa_decode_cell.sv
// Combinational 1-bit full adder built from a 3-to-8 one-hot minterm decode
// ORed through the sum and carry minterm sets.
module fa_decode_cell
    import serial_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    logic [2:0] w_idx;
    logic [7:0] w_dec;

    assign w_idx = {a, b, c};

    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
        assign w_dec[gi] = (w_idx == 3'(gi));
    end

    assign s  = |(w_dec & SUM_MINTERMS);
    assign co = |(w_dec & CARRY_MINTERMS);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams operand bits LSB first through a single
// full-adder cell, one bit per cycle, with valid/ready on both sides.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;

    fa_decode_cell u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .c  (r_carry),
        .s  (w_s),
        .co (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)       w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == LAST)  w_state_next = ST_DONE;
            ST_DONE: if (out_ready)      w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // The result registers double as the sum/cout outputs, so they are
    // cleared on the handshake that returns the block to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_carry  <= cin;
                        r_sum_sr <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_sum_sr <= '0;
                        r_carry  <= 1'b0;
                    end
                end
                default: begin
                    r_sum_sr <= '0;
                    r_carry  <= 1'b0;
                end
            endcase
        end
    end

    assign sum  = r_sum_sr;
    assign cout = r_carry;

endmodule
